lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of load/store data and result.
REQ-002 Parameter: ADDR_WIDTH, default 32, width of memory address.
REQ-003 i_sys_clk  in  1  single clock; all state updates on the rising edge.
REQ-004 i_sys_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_sys_valid  in  1  upstream (EXU) request valid.
REQ-006 o_sys_ready  out  1  LSU can accept a request this cycle.
REQ-007 i_ram_rd_en / i_ram_wr_en  in  1 each  load / store request; neither set means non-memory op.
REQ-008 i_ram_type  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU; other codes are illegal.
REQ-009 i_alu_res  in  DATA_WIDTH  effective address and pass-through ALU result.
REQ-010 i_ram_wr_data  in  DATA_WIDTH  store data, right-aligned.
REQ-011 o_mem_req / i_mem_gnt  out/in  1  bus request; accepted when both are high on the same edge.
REQ-012 o_mem_we, o_mem_addr (ADDR_WIDTH, word-aligned), o_mem_wdata (DATA_WIDTH), o_mem_be (4)  out  bus command.
REQ-013 i_mem_rvalid / i_mem_rdata  in  1 / DATA_WIDTH  response, at least 1 cycle after grant, for both loads and stores.
REQ-014 o_sys_valid / i_sys_ready  out/in  1  result handshake to WBU.
REQ-015 o_ram_res  out  DATA_WIDTH  aligned, extended load data.
REQ-016 o_alu_res  out  DATA_WIDTH  registered copy of i_alu_res.
REQ-017 o_mis_err  out  1  misaligned or illegal-type access flag, valid with o_sys_valid.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, DONE; encoding is free.
REQ-019 o_sys_ready SHALL be 1 only in IDLE; a request is taken on a rising edge with i_sys_valid and o_sys_ready high.
REQ-020 At capture, register address, data, type, rd/wr flags and i_alu_res.
REQ-021 Non-memory op: IDLE->DONE, o_sys_valid high the next cycle (latency 1), o_ram_res=0.
REQ-022 Misalignment rules: H/HU needs addr[0]=0; W needs addr[1:0]=0. A misaligned access or illegal type SHALL go IDLE->DONE with o_mis_err=1 and no bus request.
REQ-023 Legal access: IDLE->REQ; o_mem_req held high with a stable command until grant.
REQ-024 Grant: REQ->WAIT, o_mem_req drops on the following cycle.
REQ-025 i_mem_rvalid in WAIT: WAIT->DONE. Loads latch i_mem_rdata; stores ignore it.
REQ-026 i_mem_rvalid outside WAIT SHALL be ignored.
REQ-027 o_mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-028 Store byte enables: B -> 1<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111.
REQ-029 Store data: o_mem_wdata is wr_data replicated across lanes (byte x4, half x2).
REQ-030 Load data: select the lane by addr[1:0], then sign-extend for B/H or zero-extend for BU/HU; W passes through.
REQ-031 DONE: o_sys_valid=1; o_ram_res, o_alu_res and o_mis_err held stable until i_sys_ready, then DONE->IDLE.
REQ-032 No back-to-back acceptance in DONE; the next request waits for IDLE (minimum 2-cycle issue interval).
REQ-033 Minimum load latency, capture to o_sys_valid: 3 cycles, with grant in the REQ cycle and rvalid the next cycle.
REQ-034 All outputs not listed as held SHALL be 0 when not asserted.

Reset
REQ-035 Reset assertion SHALL immediately force state IDLE.
REQ-036 Reset values: o_mem_req=0, o_mem_we=0, o_mem_be=0, o_mem_addr=0, o_mem_wdata=0.
REQ-037 Reset values: o_sys_valid=0, o_ram_res=0, o_alu_res=0, o_mis_err=0, o_sys_ready=1.
REQ-038 Reset mid-transaction SHALL abandon the access; responses pending from before reset are discarded via REQ-026.

Verification
REQ-039 LB at 0x1003, rdata 0x80FF_FF12, immediate gnt, rvalid +1 -> o_ram_res=0xFFFF_FF80 three cycles after capture.
REQ-040 SH at 0x2002, data 0x0000_BEEF -> o_mem_be=4'b1100, o_mem_wdata=0xBEEF_BEEF, o_mem_addr=0x2000.
REQ-041 LW at 0x3001 -> o_mis_err=1, no o_mem_req pulse, o_sys_valid the next cycle.
REQ-042 gnt withheld 5 cycles, i_sys_ready low 3 cycles in DONE -> command stable throughout REQ; outputs stable throughout DONE.
REQ-043 Non-memory op with i_alu_res=0x1234 -> o_alu_res=0x1234, o_ram_res=0, latency 1.
REQ-044 Reset asserted in WAIT, late rvalid after release -> IDLE, no o_sys_valid, o_sys_ready=1.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: turns one EXU request into a single aligned bus access,
// then returns the extended load data, the ALU pass-through and the error flag to the WBU.
module lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_sys_valid,
    output logic                  o_sys_ready,
    input  logic                  i_ram_rd_en,
    input  logic                  i_ram_wr_en,
    input  logic [2:0]            i_ram_type,
    input  logic [DATA_WIDTH-1:0] i_alu_res,
    input  logic [DATA_WIDTH-1:0] i_ram_wr_data,
    output logic                  o_mem_req,
    input  logic                  i_mem_gnt,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]            o_mem_be,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_sys_valid,
    input  logic                  i_sys_ready,
    output logic [DATA_WIDTH-1:0] o_ram_res,
    output logic [DATA_WIDTH-1:0] o_alu_res,
    output logic                  o_mis_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    localparam logic [2:0] T_B  = 3'd0;
    localparam logic [2:0] T_H  = 3'd1;
    localparam logic [2:0] T_W  = 3'd2;
    localparam logic [2:0] T_BU = 3'd4;
    localparam logic [2:0] T_HU = 3'd5;

    function automatic logic type_legal(input logic [2:0] t);
        case (t)
            T_B, T_H, T_W, T_BU, T_HU: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] t, input logic [1:0] off);
        case (t)
            T_H, T_HU: return off[0];
            T_W:       return (off != 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] t, input logic [1:0] off);
        case (t)
            T_B, T_BU: return 4'b0001 << off;
            T_H, T_HU: return 4'b0011 << off;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_data(input logic [2:0] t,
                                                         input logic [DATA_WIDTH-1:0] wd);
        case (t)
            T_B, T_BU: return {(DATA_WIDTH/8){wd[7:0]}};
            T_H, T_HU: return {(DATA_WIDTH/16){wd[15:0]}};
            default:   return wd;
        endcase
    endfunction

    // Lane select by byte offset, then sign/zero extension by access type.
    function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [2:0] t, input logic [1:0] off,
                                                       input logic [DATA_WIDTH-1:0] rd);
        logic [DATA_WIDTH-1:0] lane;
        lane = rd >> {off, 3'b000};
        case (t)
            T_B:     return {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
            T_BU:    return {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
            T_H:     return {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
            T_HU:    return {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
            default: return lane;
        endcase
    endfunction

    state_e                state_q, state_d;
    logic [1:0]            off_q, off_d;
    logic [2:0]            type_q, type_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic                  sys_ready_q, sys_ready_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic                  sys_valid_q, sys_valid_d;
    logic [DATA_WIDTH-1:0] ram_res_q, ram_res_d;
    logic [DATA_WIDTH-1:0] alu_res_q, alu_res_d;
    logic                  mis_err_q, mis_err_d;
    logic                  mem_op_s;
    logic                  req_legal_s;

    // Next-state and next-output logic; every output is a register cleared outside its phase.
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        type_d      = type_q;
        wr_d        = wr_q;
        alu_d       = alu_q;
        sys_ready_d = sys_ready_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        sys_valid_d = sys_valid_q;
        ram_res_d   = ram_res_q;
        alu_res_d   = alu_res_q;
        mis_err_d   = mis_err_q;
        mem_op_s    = i_ram_rd_en | i_ram_wr_en;
        req_legal_s = type_legal(i_ram_type) && !misaligned(i_ram_type, i_alu_res[1:0]);
        case (state_q)
            S_IDLE: begin
                if (i_sys_valid) begin
                    off_d       = i_alu_res[1:0];
                    type_d      = i_ram_type;
                    wr_d        = i_ram_wr_en;
                    alu_d       = i_alu_res;
                    sys_ready_d = 1'b0;
                    if (mem_op_s && req_legal_s) begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = i_ram_wr_en;
                        mem_addr_d  = {i_alu_res[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = i_ram_wr_en ? store_data(i_ram_type, i_ram_wr_data)
                                                  : {DATA_WIDTH{1'b0}};
                        mem_be_d    = store_be(i_ram_type, i_alu_res[1:0]);
                    end else begin
                        // Non-memory ops and rejected accesses both finish without a bus cycle.
                        state_d     = S_DONE;
                        sys_valid_d = 1'b1;
                        ram_res_d   = {DATA_WIDTH{1'b0}};
                        alu_res_d   = i_alu_res;
                        mis_err_d   = mem_op_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (i_mem_gnt) begin
                    state_d     = S_WAIT;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {ADDR_WIDTH{1'b0}};
                    mem_wdata_d = {DATA_WIDTH{1'b0}};
                    mem_be_d    = 4'b0000;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (i_mem_rvalid) begin
                    state_d     = S_DONE;
                    sys_valid_d = 1'b1;
                    ram_res_d   = wr_q ? {DATA_WIDTH{1'b0}} : load_ext(type_q, off_q, i_mem_rdata);
                    alu_res_d   = alu_q;
                    mis_err_d   = 1'b0;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (i_sys_ready) begin
                    state_d     = S_IDLE;
                    sys_ready_d = 1'b1;
                    sys_valid_d = 1'b0;
                    ram_res_d   = {DATA_WIDTH{1'b0}};
                    alu_res_d   = {DATA_WIDTH{1'b0}};
                    mis_err_d   = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                sys_ready_d = 1'b1;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = {ADDR_WIDTH{1'b0}};
                mem_wdata_d = {DATA_WIDTH{1'b0}};
                mem_be_d    = 4'b0000;
                sys_valid_d = 1'b0;
                ram_res_d   = {DATA_WIDTH{1'b0}};
                alu_res_d   = {DATA_WIDTH{1'b0}};
                mis_err_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight access.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q     <= S_IDLE;
            off_q       <= 2'b00;
            type_q      <= 3'b000;
            wr_q        <= 1'b0;
            alu_q       <= {DATA_WIDTH{1'b0}};
            sys_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q <= {DATA_WIDTH{1'b0}};
            mem_be_q    <= 4'b0000;
            sys_valid_q <= 1'b0;
            ram_res_q   <= {DATA_WIDTH{1'b0}};
            alu_res_q   <= {DATA_WIDTH{1'b0}};
            mis_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            type_q      <= type_d;
            wr_q        <= wr_d;
            alu_q       <= alu_d;
            sys_ready_q <= sys_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            sys_valid_q <= sys_valid_d;
            ram_res_q   <= ram_res_d;
            alu_res_q   <= alu_res_d;
            mis_err_q   <= mis_err_d;
        end
    end

    assign o_sys_ready = sys_ready_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_be    = mem_be_q;
    assign o_sys_valid = sys_valid_q;
    assign o_ram_res   = ram_res_q;
    assign o_alu_res   = alu_res_q;
    assign o_mis_err   = mis_err_q;

endmodule
